// File: rtl/shift_issue_ctrl.sv
// Issue/capture stage in front of the combinational shifter: registers a request onto the
// shifter inputs, waits SETTLE_CYCLES edges, then holds the captured result until it is taken.
// Optional zero-amount bypass of the settle wait: define SHIFT_ZERO_FASTPATH_EN.
module shift_issue_ctrl #(
   parameter int DATA_W        = 8,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic [1:0]        i_req_op,
   input  logic [DATA_W-1:0] i_req_data,
   input  logic [7:0]        i_req_amt,
   output logic [DATA_W-1:0] o_sh_data1,
   output logic [7:0]        o_sh_data2,
   output logic [1:0]        o_sh_mode,
   input  logic [DATA_W-1:0] i_sh_result,
   output logic              o_res_valid,
   input  logic              i_res_ready,
   output logic [DATA_W-1:0] o_res_data,
   output logic              o_busy
);

   localparam int CNT_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);

   generate
      if (SETTLE_CYCLES < 1) begin : g_bad_settle
         $error("shift_issue_ctrl: SETTLE_CYCLES must be >= 1");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SETTLE = 2'b01,
      HOLD   = 2'b10
   } state_t;

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;
   localparam logic [1:0] OP_ROR = 2'b11;

   // DATA2 layout: [7] direction (1 = right), [6:0] amount clamped to what each op can use
   function automatic logic [7:0] enc_data2(input logic [1:0] op, input logic [7:0] amt);
      logic [6:0] sat127;
      logic [6:0] sat7;
      sat127 = (amt > 8'd127) ? 7'd127 : amt[6:0];
      sat7   = (amt > 8'd7)   ? 7'd7   : amt[6:0];
      case (op)
         OP_SLL:  enc_data2 = {1'b0, sat127};
         OP_SRL:  enc_data2 = {1'b1, sat127};
         OP_SRA:  enc_data2 = {1'b1, sat7};
         OP_ROR:  enc_data2 = {1'b1, 4'b0000, amt[2:0]};
         default: enc_data2 = 8'h00;
      endcase
   endfunction

   function automatic logic [1:0] enc_mode(input logic [1:0] op);
      case (op)
         OP_SLL:  enc_mode = 2'b01;
         OP_SRL:  enc_mode = 2'b01;
         OP_SRA:  enc_mode = 2'b10;
         OP_ROR:  enc_mode = 2'b11;
         default: enc_mode = 2'b01;
      endcase
   endfunction

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic              w_accept;
   logic              w_capture;
   logic              w_bypass;
   logic              w_fast_ok;
   logic [7:0]        w_enc_data2;

   assign w_enc_data2 = enc_data2(i_req_op, i_req_amt);

`ifdef SHIFT_ZERO_FASTPATH_EN
   assign w_fast_ok = (w_enc_data2[6:0] == 7'd0);
`else
   assign w_fast_ok = 1'b0;
`endif

   assign o_req_ready = (r_state == IDLE);
   assign o_busy      = (r_state != IDLE);

   // State register
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and handshake decode
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_capture   = 1'b0;
      w_bypass    = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_req_valid) begin
               w_accept = 1'b1;
               if (w_fast_ok) begin
                  w_bypass    = 1'b1;
                  w_state_nxt = HOLD;
               end else begin
                  w_state_nxt = SETTLE;
               end
            end else begin
               w_state_nxt = IDLE;
            end
         end
         SETTLE: begin
            if (r_cnt == CNT_W'(1)) begin
               w_capture   = 1'b1;
               w_state_nxt = HOLD;
            end else begin
               w_state_nxt = SETTLE;
            end
         end
         HOLD: begin
            if (i_res_ready) begin
               w_state_nxt = IDLE;
            end else begin
               w_state_nxt = HOLD;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Operand, counter and result registers
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_cnt       <= '0;
         o_sh_data1  <= '0;
         o_sh_data2  <= 8'h00;
         o_sh_mode   <= 2'b01;
         o_res_data  <= '0;
         o_res_valid <= 1'b0;
      end else begin
         if (w_accept) begin
            o_sh_data1 <= i_req_data;
            o_sh_data2 <= w_enc_data2;
            o_sh_mode  <= enc_mode(i_req_op);
            r_cnt      <= CNT_W'(SETTLE_CYCLES);
         end else if (r_state == SETTLE) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end else begin
            r_cnt <= r_cnt;
         end
         if (w_bypass) begin
            o_res_data  <= i_req_data;
            o_res_valid <= 1'b1;
         end else if (w_capture) begin
            o_res_data  <= i_sh_result;
            o_res_valid <= 1'b1;
         end else if ((r_state == HOLD) && i_res_ready) begin
            o_res_valid <= 1'b0;
         end else begin
            o_res_valid <= o_res_valid;
         end
      end
   end

endmodule

// File: tb/tb_shift_issue_ctrl.sv
// Directed bench for shift_issue_ctrl with a behavioural shifter model closing the loop.
module tb_shift_issue_ctrl;

   logic       clk;
   logic       rst;
   logic       req_valid;
   logic       req_ready;
   logic [1:0] req_op;
   logic [7:0] req_data;
   logic [7:0] req_amt;
   logic [7:0] sh_data1;
   logic [7:0] sh_data2;
   logic [1:0] sh_mode;
   logic [7:0] sh_result;
   logic       res_valid;
   logic       res_ready;
   logic [7:0] res_data;
   logic       busy;

   int checks = 0;
   int errors = 0;

   shift_issue_ctrl #(.DATA_W(8), .SETTLE_CYCLES(1)) dut (
      .i_clk       (clk),
      .i_reset     (rst),
      .i_req_valid (req_valid),
      .o_req_ready (req_ready),
      .i_req_op    (req_op),
      .i_req_data  (req_data),
      .i_req_amt   (req_amt),
      .o_sh_data1  (sh_data1),
      .o_sh_data2  (sh_data2),
      .o_sh_mode   (sh_mode),
      .i_sh_result (sh_result),
      .o_res_valid (res_valid),
      .i_res_ready (res_ready),
      .o_res_data  (res_data),
      .o_busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference shifter fed from the stage's outputs
   function automatic logic [7:0] shifter(input logic [7:0] d, input logic [7:0] d2, input logic [1:0] m);
      logic [6:0] a;
      a = d2[6:0];
      if (!d2[7]) shifter = (a >= 7'd8) ? 8'h00 : (d << a);
      else if (m == 2'b10) shifter = 8'($signed(d) >>> ((a >= 7'd7) ? 7'd7 : a));
      else if (m == 2'b11) shifter = (d >> a[2:0]) | (d << (4'd8 - {1'b0, a[2:0]}));
      else shifter = (a >= 7'd8) ? 8'h00 : (d >> a);
   endfunction

   always_comb sh_result = shifter(sh_data1, sh_data2, sh_mode);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ready"}, 32'(req_ready), 32'd1);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_rvalid"}, 32'(res_valid), 32'd0);
      chk({tag, "_d1"}, 32'(sh_data1), 32'h00);
      chk({tag, "_d2"}, 32'(sh_data2), 32'h00);
      chk({tag, "_mode"}, 32'(sh_mode), 32'h1);
      chk({tag, "_rdata"}, 32'(res_data), 32'h00);
   endtask

   // One full transaction: accept, wait for result (bounded), check, release
   task automatic do_req(input string tag, input logic [1:0] op, input logic [7:0] d, input logic [7:0] amt,
                         input logic [7:0] exp_d2, input logic [1:0] exp_mode, input logic [7:0] exp_res,
                         input int exp_lat);
      int n;
      req_valid = 1'b1; req_op = op; req_data = d; req_amt = amt;
      chk({tag, "_ready_idle"}, 32'(req_ready), 32'd1);
      tick();
      req_valid = 1'b0;
      chk({tag, "_d1"}, 32'(sh_data1), 32'(d));
      chk({tag, "_d2"}, 32'(sh_data2), 32'(exp_d2));
      chk({tag, "_mode"}, 32'(sh_mode), 32'(exp_mode));
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      n = 0;
      while (!res_valid && n < 10) begin
         tick();
         n++;
      end
      chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
      chk({tag, "_rdata"}, 32'(res_data), 32'(exp_res));
      chk({tag, "_ready_hold"}, 32'(req_ready), 32'd0);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk({tag, "_rvalid_drop"}, 32'(res_valid), 32'd0);
      chk({tag, "_idle"}, 32'(req_ready), 32'd1);
   endtask

   initial begin
      logic [7:0] held;
      int fast_lat;
      rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_data = 8'h00; req_amt = 8'h00; res_ready = 1'b0;
      #3;
      chk_reset_vals("rst");
      // request under reset must be ignored
      req_valid = 1'b1; req_data = 8'h3C; req_amt = 8'd2;
      tick();
      chk("rst_ign_busy", 32'(busy), 32'd0);
      chk("rst_ign_d1", 32'(sh_data1), 32'h00);
      req_valid = 1'b0;
      tick();
      rst = 1'b0;
      tick();

      // T1..T3
      do_req("t1_sll", 2'b00, 8'hAA, 8'd1,   8'h01, 2'b01, 8'h54, 1);
      do_req("t2_srl", 2'b01, 8'hF0, 8'd3,   8'h83, 2'b01, 8'h1E, 1);
      do_req("t2_sll8", 2'b00, 8'hFF, 8'd8,  8'h08, 2'b01, 8'h00, 1);
      do_req("t2_srl200", 2'b01, 8'hFF, 8'd200, 8'hFF, 2'b01, 8'h00, 1);
      do_req("t3_sra", 2'b10, 8'h80, 8'd200, 8'h87, 2'b10, 8'hFF, 1);
      do_req("t3_ror", 2'b11, 8'h81, 8'd9,   8'h81, 2'b11, 8'hC0, 1);

      // RES_READY high outside HOLD is harmless
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk("rdy_idle_busy", 32'(busy), 32'd0);

      // T4 backpressure: new request held high while result is stalled
      req_valid = 1'b1; req_op = 2'b01; req_data = 8'h96; req_amt = 8'd2;
      tick();
      tick();
      chk("t4_capture", 32'(res_valid), 32'd1);
      held = res_data;
      chk("t4_rdata", 32'(held), 32'h25);
      req_data = 8'h11; req_amt = 8'd5;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t4_stable", 32'(res_data), 32'(held));
         chk("t4_ready", 32'(req_ready), 32'd0);
         chk("t4_busy", 32'(busy), 32'd1);
         chk("t4_noaccept", 32'(sh_data1), 32'h96);
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      req_valid = 1'b0;
      chk("t4_release", 32'(res_valid), 32'd0);
      chk("t4_idle", 32'(req_ready), 32'd1);
      chk("t4_no_same_cycle", 32'(sh_data1), 32'h96);
      tick();

      // T5 async reset mid-SETTLE
      req_valid = 1'b1; req_op = 2'b00; req_data = 8'h0F; req_amt = 8'd4;
      tick();
      req_valid = 1'b0;
      chk("t5_settle", 32'(busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk_reset_vals("t5");
      tick();
      rst = 1'b0;
      tick();
      do_req("t5_after", 2'b00, 8'h0F, 8'd4, 8'h04, 2'b01, 8'hF0, 1);

      // T6 zero amount
`ifdef SHIFT_ZERO_FASTPATH_EN
      fast_lat = 0;
`else
      fast_lat = 1;
`endif
      do_req("t6_zero", 2'b00, 8'h5A, 8'd0, 8'h00, 2'b01, 8'h5A, fast_lat);
      do_req("t6_ror8", 2'b11, 8'h5A, 8'd8, 8'h80, 2'b11, 8'h5A, fast_lat);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule
